mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the E-stage operand values (rs in rs_val, rt in rt_val) and the decoded MD operation from the E-stage control.
- Models multi-cycle latency with a busy counter and commits HI/LO at the end of the operation.
- Drives stall_req back to hazard control, which freezes the D register and clears the E register while an MD instruction must wait.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an MD op; sampled at posedge
op  input  4  MD operation code (package encoding)
rs_val  input  32  forwarded rs operand in E
rt_val  input  32  forwarded rt operand in E
cancel  input  1  abort the in-flight op (exception flush)
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  operation in flight
stall_req  output  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU/MADD*/MSUB*)

Behaviour:
- Reset:
  - hi=0, lo=0, busy=0, counter=0, state IDLE.
  - Reset mid-operation discards the pending result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE -> RUN (start=1, op is a multi-cycle op, cancel=0, at posedge T):
  - Latch the 64-bit result into the pending register.
  - counter <= N-1, where N = MUL_CYCLES or DIV_CYCLES.
  - busy=1 for cycles T+1..T+N.
- RUN with counter==0 at posedge:
  - Commit pending to hi/lo; go to IDLE.
  - New hi/lo and busy=0 are visible in cycle T+N+1.
- RUN otherwise: decrement counter.
- start while busy: ignored. Hazard control must not issue it, because stall_req is asserted.
- MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the posedge; no busy. Ignored while busy.
- MFHI/MFLO are not ops of this block. Readers use hi/lo directly and stall on stall_req.
- cancel=1:
  - In RUN: go to IDLE, busy=0, hi/lo unchanged.
  - With start in the same cycle: start is ignored; cancel wins.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend (rs).
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: hi/lo unchanged at commit; full DIV_CYCLES latency is still taken.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- op = MD_NONE with start=1: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - {hi,lo} <= {hi,lo} ± product (signed or unsigned), with 64-bit wrap-around.
  - The accumulate uses the hi/lo values at commit time.
  - Latency is MUL_CYCLES.
- Undefined: these opcodes behave as MD_NONE, and stall_req does not assert for them.

Decomposition:
- Package mdu_pkg contains:
  - op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10
  - state encodings IDLE/RUN
  - a function classifying multi-cycle ops
- One natural sub-module, mdu_calc: purely combinational; (op, rs_val, rt_val, hi, lo) -> 64-bit pending result plus a div-by-zero flag.
- mult_div_unit keeps the FSM, counter and HI/LO.

Test Plan:
- reset, then MULT with rs=0xFFFFFFFE (-2), rt=3 at T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU with rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU with rt=0 -> after 10 cycles hi/lo unchanged.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never asserts. A second MULT issued while busy -> ignored; stall_req=1 throughout.
- DIV started; cancel asserted at the 4th busy cycle -> busy=0 next cycle, hi/lo keep their previous values. start+cancel in the same cycle -> no busy.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> after 5 cycles hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and stall_req=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings plus op classifiers.
// MADD/MADDU/MSUB/MSUBU are only classified as multi-cycle when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_multi(input logic [3:0] op);
        return is_mul(op) || is_div(op);
    endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational MD datapath: computes the 64-bit {hi,lo} result for the op and flags divide-by-zero.
// Accumulate ops (MDU_MADD_EN) fold the current hi/lo into the result.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic [31:0]        rs_mag;
    logic [31:0]        rt_mag;
    logic [31:0]        divisor;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [31:0]        quo;
    logic [31:0]        rem;

    assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign signed_div = (op == MD_DIV);
    assign rs_mag     = (signed_div && rs_val[31]) ? -rs_val : rs_val;
    assign rt_mag     = (signed_div && rt_val[31]) ? -rt_val : rt_val;
    assign divisor    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    assign quo_u      = rs_mag / divisor;
    assign rem_u      = rs_mag % divisor;
    assign quo        = (signed_div && (rs_val[31] ^ rt_val[31])) ? -quo_u : quo_u;
    assign rem        = (signed_div && rs_val[31]) ? -rem_u : rem_u;

    assign div_zero = is_div(op) && (rt_val == 32'd0);

    always_comb begin
        result = {hi, lo};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV,
            MD_DIVU:  result = div_zero ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: busy-counter latency model with HI/LO commit at the end.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [63:0] pending;
    logic        pending_dz;
    logic [63:0] calc_result;
    logic        calc_dz;
    logic        launch;
    logic        commit;
    logic        write_hi;
    logic        write_lo;

    mdu_calc u_calc (
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo),
        .result   (calc_result),
        .div_zero (calc_dz)
    );

    assign busy      = (state == RUN);
    assign stall_req = busy || (start && is_multi(op));

    always_comb begin
        state_next = state;
        count_next = count;
        launch     = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_multi(op)) begin
                        launch     = 1'b1;
                        state_next = RUN;
                        count_next = is_div(op) ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);
                    end else begin
                        write_hi = (op == MD_MTHI);
                        write_lo = (op == MD_MTLO);
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count == 4'd0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (commit && !pending_dz) begin
                hi <= pending[63:32];
                lo <= pending[31:0];
            end
            if (write_hi) hi <= rs_val;
            if (write_lo) lo <= rs_val;
        end
    end

    // Result is captured at launch; hi/lo cannot change while busy, so accumulates see commit-time values.
    always_ff @(posedge clk) begin
        if (launch) begin
            pending    <= calc_result;
            pending_dz <= calc_dz;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo,busy length}, a monitor pops on busy falling.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cancel    (cancel),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_op(input logic [31:0] h, input logic [31:0] l, input int len);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic monitor();
        logic prev_busy = 1'b0;
        int   len       = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                len++;
            end else if (prev_busy === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 32'(len), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_hi", hi, e.hi);
                    check("sb_lo", lo, e.lo);
                    check("sb_busy_len", 32'(len), 32'(e.len));
                end
                len = 0;
            end
            prev_busy = busy;
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic canc, input logic exp_stall);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        cancel = canc;
        #1;
        check("stall_on_issue", 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = MD_NONE;
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input logic chk_stall);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (chk_stall) check("stall_while_busy", 32'(stall_req), 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        reset  = 1'b1;
        start  = 1'b0;
        op     = MD_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);
        reset = 1'b0;

        expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
        wait_idle(1'b0);

        expect_op(32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        wait_idle(1'b0);

        expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        wait_idle(1'b0);

        expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIVU, 32'd5, 32'd0, 1'b0, 1'b1);
        wait_idle(1'b0);

        expect_op(32'h0000_0000, 32'h8000_0000, 10);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_idle(1'b0);

        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'h8000_0000);
        check("mthi_no_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'h0000_0009, 32'd0, 1'b0, 1'b0);
        check("mtlo_lo", lo, 32'h0000_0009);
        check("mtlo_hi_kept", hi, 32'h1234_5678);

        expect_op(32'd0, 32'd42, 5);
        issue(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b1);
        issue(MD_MULT, 32'd100, 32'd100, 1'b0, 1'b1);
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        wait_idle(1'b1);
        check("ignored_while_busy_hi", hi, 32'd0);

        expect_op(32'd0, 32'd42, 4);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        wait_idle(1'b0);

        issue(MD_DIV, 32'd100, 32'd7, 1'b1, 1'b1);
        check("start_cancel_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("start_cancel_hi", hi, 32'd0);
        check("start_cancel_lo", lo, 32'd42);

        issue(MD_NONE, 32'd3, 32'd4, 1'b0, 1'b0);
        check("none_busy", 32'(busy), 32'd0);
        check("none_lo", lo, 32'd42);

        issue(MD_MTHI, 32'h5555_5555, 32'd0, 1'b0, 1'b0);
        expect_op(32'd0, 32'd0, 3);
        issue(MD_DIV, 32'd50, 32'd5, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midop_reset_hi", hi, 32'd0);
        check("midop_reset_lo", lo, 32'd0);
        wait_idle(1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("midop_reset_stays_lo", lo, 32'd0);

        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        expect_op(32'd1, 32'd0, 5);
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0, 1'b1);
        wait_idle(1'b0);
`else
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
        check("maddu_off_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
